// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential PC, one outstanding imem read, small instruction FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_inst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_curr,
    output logic [31:0] out_pc_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [PTR_W-1:0]   head_reg, head_next;
    logic [PTR_W-1:0]   tail_reg, tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               fresh_reg;

    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic [31:0]        pc_inc;
    logic               resp_ok;
    logic               fifo_empty;
    logic               deq;
    logic               fifo_deq;
    logic               enq;
    logic               space;
    logic               issue;

    assign pc_inc     = pc_reg + 32'd4;
    assign fifo_empty = (count_reg == '0);
    // A response is only accepted while genuinely outstanding and not squashed this cycle.
    assign resp_ok    = (state_reg == WAIT) && imem_resp && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = resp_ok && fifo_empty;
    assign out_valid   = !fifo_empty || bypass_hit;
    assign out_inst    = bypass_hit ? imem_rdata : inst_mem[head_reg];
    assign out_pc_curr = bypass_hit ? pc_reg     : pc_mem[head_reg];
    // A bypassed word that decode takes is never written into the FIFO.
    assign enq         = resp_ok && !(bypass_hit && !stall_inst);
`else
    assign out_valid   = !fifo_empty;
    assign out_inst    = inst_mem[head_reg];
    assign out_pc_curr = pc_mem[head_reg];
    assign enq         = resp_ok;
`endif

    assign out_pc_next = out_pc_curr + 32'd4;
    assign deq         = out_valid && !stall_inst && !redirect_valid;
    assign fifo_deq    = deq && !fifo_empty;

    always_comb begin
        count_next = count_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        if (enq && !fifo_deq) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!enq && fifo_deq) begin
            count_next = count_reg - CNT_W'(1);
        end
        if (enq) begin
            tail_next = tail_reg + PTR_W'(1);
        end
        if (fifo_deq) begin
            head_next = head_reg + PTR_W'(1);
        end
        if (redirect_valid) begin
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
        end
    end

    // Space is judged against the post-update occupancy so a same-cycle dequeue frees a slot.
    assign space = (count_next < CNT_W'(DEPTH));

    assign issue = rst && !redirect_valid && space &&
                   ((state_reg == IDLE) || ((state_reg == WAIT) && imem_resp));

    assign imem_rmask = issue ? 4'hF : 4'h0;
    assign imem_addr  = resp_ok ? pc_inc : pc_reg;

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (resp_ok) begin
            pc_next = pc_inc;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_resp ? IDLE : DROP;
                end else if (imem_resp) begin
                    state_next = issue ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (imem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            fresh_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            fresh_reg <= 1'b0;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail_reg] <= imem_rdata;
            pc_mem[tail_reg]   <= pc_reg;
        end
    end

    // A response in IDLE is illegal, except a stray one left over from before a reset.
    resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(imem_resp && (state_reg == IDLE) && !fresh_reg));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, back-pressure, redirects, reset and PC wrap.
module tb_fetch_stage;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_inst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc_curr;
    logic [31:0] out_pc_next;

    int          checks = 0;
    int          errors = 0;
    logic        req_seen = 1'b0;
    logic [31:0] req_addr = 32'h0;

    fetch_stage #(.RESET_PC(32'h1eceb000), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_inst     (stall_inst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc_curr    (out_pc_curr),
        .out_pc_next    (out_pc_next)
    );

    always #5 clk = ~clk;

    // Latch this cycle's request, advance to just after the next rising edge.
    task automatic step();
        req_seen = (imem_rmask === 4'hF);
        req_addr = imem_addr;
        if (req_seen) $display("req addr=%h", imem_addr);
        @(posedge clk);
        #1;
    endtask

    // Memory model: data word is the bitwise inverse of its address.
    task automatic respond();
        imem_resp  = req_seen;
        imem_rdata = ~req_addr;
    endtask

    task automatic do_reset(input logic stall);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_resp      = 1'b0;
        imem_rdata     = 32'h0;
        stall_inst     = stall;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rmask !== 4'h0 || imem_addr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b rmask=%h addr=%h want 0 0 1eceb000",
                     out_valid, imem_rmask, imem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL reset_first_req: got rmask=%h addr=%h want f 1eceb000", imem_rmask, imem_addr);
        end
        step();
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        logic [31:0] first_pc;
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        step();
        respond();
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb004) begin
            errors++;
            $display("FAIL seq_req1: got rmask=%h addr=%h want f 1eceb004", imem_rmask, imem_addr);
        end
        checks++;
        if (out_valid !== BYP) begin
            errors++;
            $display("FAIL seq_latency: got valid=%b want %b in resp cycle", out_valid, BYP);
        end
        first_pc = out_valid ? out_pc_curr : 32'hffffffff;
        step();
        respond();
        #1;
        if (first_pc === 32'hffffffff) first_pc = out_pc_curr;
        checks++;
        if (first_pc !== 32'h1eceb000) begin
            errors++;
            $display("FAIL seq_first_pc: got %h want 1eceb000", first_pc);
        end
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb008) begin
            errors++;
            $display("FAIL seq_req2: got rmask=%h addr=%h want f 1eceb008", imem_rmask, imem_addr);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc_curr !== (BYP ? 32'h1eceb004 : 32'h1eceb000) ||
            out_pc_next !== (BYP ? 32'h1eceb008 : 32'h1eceb004) || out_inst !== ~out_pc_curr) begin
            errors++;
            $display("FAIL seq_head_a: got valid=%b curr=%h next=%h inst=%h", out_valid, out_pc_curr,
                     out_pc_next, out_inst);
        end
        step();
        respond();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc_curr !== (BYP ? 32'h1eceb008 : 32'h1eceb004) ||
            out_pc_next !== (BYP ? 32'h1eceb00c : 32'h1eceb008)) begin
            errors++;
            $display("FAIL seq_head_b: got valid=%b curr=%h next=%h", out_valid, out_pc_curr, out_pc_next);
        end
        step();
        imem_resp = 1'b0;
        $display("test_sequential done");
    endtask

    task automatic test_stall_full();
        int nreq = 0;
        do_reset(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            respond();
            #1;
            if (imem_rmask === 4'hF) nreq++;
            step();
        end
        imem_resp = 1'b0;
        #1;
        checks++;
        if (nreq !== 4) begin
            errors++;
            $display("FAIL stall_req_count: got %0d want 4", nreq);
        end
        checks++;
        if (imem_rmask !== 4'h0 || out_valid !== 1'b1 || out_pc_curr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL stall_full_hold: got rmask=%h valid=%b curr=%h want 0 1 1eceb000",
                     imem_rmask, out_valid, out_pc_curr);
        end
        stall_inst = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb010 || out_pc_curr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL stall_release: got rmask=%h addr=%h curr=%h want f 1eceb010 1eceb000",
                     imem_rmask, imem_addr, out_pc_curr);
        end
        step();
        stall_inst = 1'b1;
        respond();
        #1;
        checks++;
        if (imem_rmask !== 4'h0 || out_pc_curr !== 32'h1eceb004 || out_inst !== ~32'h1eceb004) begin
            errors++;
            $display("FAIL stall_refill: got rmask=%h curr=%h inst=%h want 0 1eceb004 %h",
                     imem_rmask, out_pc_curr, out_inst, ~32'h1eceb004);
        end
        step();
        imem_resp = 1'b0;
        $display("test_stall_full done");
    endtask

    task automatic test_redirect_wait();
        logic [31:0] got_pc = 32'h0;
        logic [31:0] got_inst = 32'h0;
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1eceb100;
        #1;
        checks++;
        if (imem_rmask !== 4'h0) begin
            errors++;
            $display("FAIL redir_no_req: got rmask=%h want 0", imem_rmask);
        end
        step();
        redirect_valid = 1'b0;
        imem_resp      = 1'b1;
        imem_rdata     = 32'hdeadbeef;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rmask !== 4'h0) begin
            errors++;
            $display("FAIL redir_drop: got valid=%b rmask=%h want 0 0", out_valid, imem_rmask);
        end
        step();
        imem_resp = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rmask !== 4'hF || imem_addr !== 32'h1eceb100) begin
            errors++;
            $display("FAIL redir_restart: got valid=%b rmask=%h addr=%h want 0 f 1eceb100",
                     out_valid, imem_rmask, imem_addr);
        end
        step();
        respond();
        #1;
        if (out_valid) begin
            got_pc   = out_pc_curr;
            got_inst = out_inst;
        end
        step();
        imem_resp = 1'b0;
        #1;
        if (out_valid) begin
            got_pc   = out_pc_curr;
            got_inst = out_inst;
        end
        checks++;
        if (got_pc !== 32'h1eceb100 || got_inst !== ~32'h1eceb100) begin
            errors++;
            $display("FAIL redir_new_head: got pc=%h inst=%h want 1eceb100 %h", got_pc, got_inst,
                     ~32'h1eceb100);
        end
        step();
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_resp();
        logic [31:0] got_pc = 32'h0;
        do_reset(1'b1);
        rst = 1'b1;
        #1;
        step();
        respond();
        #1;
        step();
        respond();
        #1;
        step();
        respond();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1eceb200;
        #1;
        checks++;
        if (imem_rmask !== 4'h0 || out_valid !== 1'b1 || out_pc_curr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL redir_resp_pre: got rmask=%h valid=%b curr=%h want 0 1 1eceb000",
                     imem_rmask, out_valid, out_pc_curr);
        end
        step();
        redirect_valid = 1'b0;
        imem_resp      = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rmask !== 4'hF || imem_addr !== 32'h1eceb200) begin
            errors++;
            $display("FAIL redir_resp_flush: got valid=%b rmask=%h addr=%h want 0 f 1eceb200",
                     out_valid, imem_rmask, imem_addr);
        end
        step();
        stall_inst = 1'b0;
        respond();
        #1;
        if (out_valid) got_pc = out_pc_curr;
        step();
        imem_resp = 1'b0;
        #1;
        if (out_valid) got_pc = out_pc_curr;
        checks++;
        if (got_pc !== 32'h1eceb200) begin
            errors++;
            $display("FAIL redir_resp_head: got %h want 1eceb200", got_pc);
        end
        step();
        $display("test_redirect_resp done");
    endtask

    task automatic test_reset_wait();
        logic [31:0] got_inst = 32'h0;
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        step();
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_rmask !== 4'h0 || imem_addr !== 32'h1eceb000) begin
            errors++;
            $display("FAIL rst_wait_state: got valid=%b rmask=%h addr=%h want 0 0 1eceb000",
                     out_valid, imem_rmask, imem_addr);
        end
        rst        = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 32'hdeadbeef;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h1eceb000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stray: got rmask=%h addr=%h valid=%b want f 1eceb000 0",
                     imem_rmask, imem_addr, out_valid);
        end
        step();
        respond();
        #1;
        if (out_valid) got_inst = out_inst;
        step();
        imem_resp = 1'b0;
        #1;
        if (out_valid) got_inst = out_inst;
        checks++;
        if (got_inst !== ~32'h1eceb000) begin
            errors++;
            $display("FAIL rst_restart_inst: got %h want %h", got_inst, ~32'h1eceb000);
        end
        step();
        $display("test_reset_wait done");
    endtask

    task automatic test_pc_wrap();
        logic [31:0] got_pc = 32'h0;
        logic [31:0] got_next = 32'h1;
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hfffffffc;
        #1;
        step();
        redirect_valid = 1'b0;
        imem_resp      = 1'b1;
        imem_rdata     = 32'hdeadbeef;
        #1;
        step();
        imem_resp = 1'b0;
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'hfffffffc) begin
            errors++;
            $display("FAIL wrap_req: got rmask=%h addr=%h want f fffffffc", imem_rmask, imem_addr);
        end
        step();
        respond();
        #1;
        checks++;
        if (imem_rmask !== 4'hF || imem_addr !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_next_req: got rmask=%h addr=%h want f 00000000", imem_rmask, imem_addr);
        end
        if (out_valid) begin
            got_pc   = out_pc_curr;
            got_next = out_pc_next;
        end
        step();
        imem_resp = 1'b0;
        #1;
        if (out_valid) begin
            got_pc   = out_pc_curr;
            got_next = out_pc_next;
        end
        checks++;
        if (got_pc !== 32'hfffffffc || got_next !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_head: got curr=%h next=%h want fffffffc 00000000", got_pc, got_next);
        end
        step();
        $display("test_pc_wrap done");
    endtask

`ifdef FETCH_BYPASS_EN
    task automatic test_bypass();
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        step();
        respond();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== ~32'h1eceb000 || out_pc_curr !== 32'h1eceb000 ||
            out_pc_next !== 32'h1eceb004) begin
            errors++;
            $display("FAIL bypass_same_cycle: got valid=%b inst=%h curr=%h next=%h",
                     out_valid, out_inst, out_pc_curr, out_pc_next);
        end
        step();
        imem_resp = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_not_written: got valid=%b want 0", out_valid);
        end
        step();
        $display("test_bypass done");
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect_wait();
        test_redirect_resp();
        test_reset_wait();
        test_pc_wrap();
`ifdef FETCH_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
